// File: rtl/booth_mult64_if.sv
// Request/response bundle for the 32x32 signed Booth multiplier.
// The master drives operands and start; the slave returns the product and status.
interface booth_mult64_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [63:0] product;
  logic [31:0] result_lo;
  logic        ovf;
  logic        busy;
  logic        ready;

  modport master (
    output start, op_a, op_b,
    input  product, result_lo, ovf, busy, ready
  );

  modport slave (
    input  start, op_a, op_b,
    output product, result_lo, ovf, busy, ready
  );
endinterface

// File: rtl/booth_mult64.sv
// Sequential radix-4 Booth multiplier: 32x32 signed -> 64-bit, one partial product per clock.
// Results are published one cycle after DONE; the working pair is a shadow of the visible product.
module booth_mult64 (
  input  logic          clk,
  input  logic          clr,
  booth_mult64_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [63:0] pair_q;      // {accumulator, remaining multiplier bits}
  logic [33:0] mcand_q;
  logic [3:0]  cnt_q;
  logic        guard_q;
  logic [63:0] product_q;
  logic        ovf_q;
  logic        busy_q;
  logic        ready_q;

  logic [33:0] mcand_x2;
  logic [33:0] pp;
  logic [33:0] sum;
  logic [63:0] pair_next;
  logic        ovf_next;

  assign mcand_x2 = {mcand_q[32:0], 1'b0};

  // Booth digit from the two low multiplier bits plus the guard bit.
  always_comb begin
    pp = '0;
    case ({pair_q[1:0], guard_q})
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_x2;
      3'b100:         pp = -mcand_x2;
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  // 34-bit add keeps the +-2A headroom; after the shift the upper half fits 32 bits again.
  always_comb begin
    sum       = {{2{pair_q[63]}}, pair_q[63:32]} + pp;
    pair_next = {sum[33:2], sum[1:0], pair_q[31:2]};
    ovf_next  = (pair_q[63:32] != {32{pair_q[31]}});
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= StIdle;
      pair_q    <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      guard_q   <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      // The DONE cycle always publishes, even if a new start arrives alongside it.
      if (state_q == StDone) begin
        product_q <= pair_q;
        ovf_q     <= ovf_next;
        ready_q   <= 1'b1;
      end
      if (bus.start) begin
        state_q <= StRun;
        pair_q  <= {32'b0, bus.op_b};
        mcand_q <= {{2{bus.op_a[31]}}, bus.op_a};
        cnt_q   <= '0;
        guard_q <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          StRun: begin
            pair_q  <= pair_next;
            guard_q <= pair_q[1];
            cnt_q   <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_q <= StDone;
            end
          end
          StDone: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.product   = product_q;
  assign bus.result_lo = product_q[31:0];
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;
  assign bus.ready     = ready_q;

endmodule

// File: doc/booth_mult64.md
BOOTH_MULT64 -- requirements
Module: booth_mult64

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32-bit operands and a 64-bit product.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 clr  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  one-cycle request: latch operands and begin a multiply.
REQ-005 op_a  input  32  signed multiplicand, two's complement.
REQ-006 op_b  input  32  signed multiplier, two's complement.
REQ-007 product  output  64  signed result; this is the value written into the 64-bit product register.
REQ-008 result_lo  output  32  product[31:0].
REQ-009 ovf  output  1  the signed result does not fit in 32 bits.
REQ-010 busy  output  1  a multiply is in progress.
REQ-011 ready  output  1  one-cycle pulse: product and ovf are valid.

Function
REQ-012 The algorithm SHALL be radix-4 modified Booth with one partial product per clock: 16 iterations, multiplicand magnitude set {0, ±A, ±2A}.
REQ-013 State SHALL be a 64-bit accumulator/multiplier register pair, a 34-bit sign-extended multiplicand, a 4-bit iteration counter, a Booth guard bit, and the FSM IDLE, RUN, DONE.
REQ-014 IDLE: busy=0 and ready=0; start=1 loads op_a and op_b, clears the counter and guard, and moves to RUN.
REQ-015 RUN: each edge adds the selected partial product to the upper accumulator, arithmetic-shifts the pair right by 2, and increments the counter; after the 16th iteration the FSM moves to DONE.
REQ-016 DONE: ready=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-017 Latency: if start is sampled at edge k, RUN spans edges k+1..k+16, and ready=1 in the cycle after edge k+17.
REQ-018 busy SHALL be 1 in RUN and in DONE, and 0 in IDLE.
REQ-019 product SHALL equal the exact 64-bit signed op_a*op_b, with no truncation, including the -2^31 * -2^31 = 2^62 case.
REQ-020 ovf SHALL be 1 iff product[63:32] is not the sign extension of product[31]; it is valid only when ready=1 and is held afterwards.
REQ-021 product, result_lo and ovf SHALL hold their last completed values in IDLE until the next completion.
REQ-022 During RUN, product SHALL NOT change; an internal shadow holds the in-flight accumulation.
REQ-023 start=1 in RUN or DONE SHALL abort the current operation without a ready pulse and restart with the new operands; the latency is counted from the new start.
REQ-024 op_a and op_b SHALL be ignored except on the edge at which start is sampled.
REQ-025 Back-to-back: start sampled in the DONE cycle SHALL still produce that cycle's ready pulse and then enter RUN; this is the only case exempt from REQ-023's abort.

Reset
REQ-026 clr=1 SHALL immediately, without waiting for a clock edge, force: FSM=IDLE, counter=0, product=0, ovf=0, busy=0, ready=0.
REQ-027 clr asserted mid-RUN SHALL discard the operation; no ready pulse follows deassertion.
REQ-028 After clr deasserts, the first start SHALL be accepted on the next rising edge.
REQ-029 clr SHALL take priority over start on the same edge.

Verification
REQ-030 start with op_a=7, op_b=-3 -> busy high for 17 cycles, ready one cycle after edge k+17, product=0xFFFFFFFFFFFFFFEB, ovf=0.
REQ-031 op_a=0x80000000, op_b=0x80000000 -> product=0x4000000000000000, ovf=1; then op_a=0x7FFFFFFF, op_b=2 -> product=0x00000000FFFFFFFE, ovf=1.
REQ-032 Start op_a=5, op_b=5, then at RUN iteration 8 start op_a=-1, op_b=1 -> single ready pulse 17 cycles after the second start, product=0xFFFFFFFFFFFFFFFF.
REQ-033 clr asserted mid-RUN, asynchronously between edges -> outputs zero immediately; no ready pulse for 40 cycles after release without a new start.
REQ-034 Start held for the DONE cycle with new operands (12, 12) -> previous ready seen, then product=144 after a further 17 cycles.
REQ-035 Randomized sweep of 10k operand pairs including 0, ±1, 0x7FFFFFFF and 0x80000000 -> product and ovf match the 64-bit signed reference product.
